// File: rtl/reg_bank_wr_arb.sv
// Round-robin write arbiter for a small register bank shared by N requesters.
// One grant every two cycles: IDLE picks and latches a winner, GNT commits it.

module reg_bank_wr_arb_cell #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // A clear in the same cycle as a write drops the write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)  q <= '0;
        else if (clr) q <= '0;
        else if (we)  q <= d;
    end
endmodule

module reg_bank_wr_arb #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] wr_addr,
    input  logic [N*W-1:0]  wr_data,
    output logic [N-1:0]    gnt,
    input  logic            clr,
    input  logic [AW-1:0]   rd_addr,
    output logic [W-1:0]    rd_data,
    output logic            busy,
    output logic [2:0]      last_id,
    output logic [15:0]     wr_cnt
);
    typedef enum logic {IDLE, GNT} state_t;

    state_t                      state, state_nxt;
    logic [2:0]                  rr_ptr, hold_id, sel_id;
    logic [AW-1:0]               hold_addr;
    logic [W-1:0]                hold_data;
    logic                        any_req;
    logic [DEPTH-1:0][W-1:0]     bank;

    // Search starts at rr_ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        int idx;
        idx     = 0;
        sel_id  = '0;
        any_req = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                sel_id  = 3'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GNT;
            GNT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            hold_id   <= '0;
            hold_addr <= '0;
            hold_data <= '0;
            last_id   <= '0;
            wr_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                hold_id   <= sel_id;
                hold_addr <= wr_addr[sel_id*AW +: AW];
                hold_data <= wr_data[sel_id*W +: W];
            end
            // The grant is consumed even when clr drops the write.
            if (state == GNT) begin
                rr_ptr  <= (hold_id == 3'(N-1)) ? 3'd0 : hold_id + 3'd1;
                last_id <= hold_id;
                wr_cnt  <= wr_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++)
            gnt[i] = (state == GNT) && (hold_id == 3'(i));
    end

    assign busy    = (state == GNT);
    assign rd_data = bank[rd_addr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        reg_bank_wr_arb_cell #(.W(W)) u_cell (
            .clk    (clk),
            .resetn (resetn),
            .clr    (clr),
            .we     ((state == GNT) && (hold_addr == AW'(i))),
            .d      (hold_data),
            .q      (bank[i])
        );
    end
endmodule

// File: tb/tb_reg_bank_wr_arb.sv
// Bench for reg_bank_wr_arb: table of single-shot arbitration vectors plus
// hand sequences for round-robin, starvation, clr collision and mid-grant reset.

module tb_reg_bank_wr_arb;
    localparam int W = 8, N = 4, DEPTH = 4, AW = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   wr_addr;
    logic [N*W-1:0]    wr_data;
    logic [N-1:0]      gnt;
    logic              clr;
    logic [AW-1:0]     rd_addr;
    logic [W-1:0]      rd_data;
    logic              busy;
    logic [2:0]        last_id;
    logic [15:0]       wr_cnt;

    reg_bank_wr_arb #(.W(W), .N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .resetn(resetn), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .gnt(gnt), .clr(clr), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .last_id(last_id), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] req; logic [1:0] addr; logic [7:0] base; int win; } vec_t;
    typedef struct { int id; logic [1:0] addr; logic [7:0] data; } exp_t;

    exp_t       sbq[$];
    logic [7:0] mbank [DEPTH];
    int         n_tests = 0, n_fail = 0;
    int         exp_cnt = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(logic [3:0] m, logic [1:0] a, logic [7:0] base);
        req = m;
        for (int i = 0; i < N; i++) begin
            wr_addr[i*AW +: AW] = a;
            wr_data[i*W +: W]   = base + 8'(i);
        end
    endtask

    // Pops the next expected grant and checks the GNT cycle outputs.
    task automatic check_gnt(string nm, output exp_t e);
        if (sbq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: grant %0h with empty scoreboard", nm, gnt);
            e = '{id: 0, addr: 2'd0, data: 8'd0};
        end else begin
            e = sbq.pop_front();
            chk({nm, "_gnt"}, 32'(gnt), 32'(1 << e.id));
            chk({nm, "_busy"}, 32'(busy), 32'd1);
            rd_addr = e.addr;
            #1;
            chk({nm, "_rd_old"}, 32'(rd_data), 32'(mbank[e.addr]));
        end
    endtask

    // Call in the IDLE cycle right after the GNT cycle.
    task automatic check_commit(string nm, exp_t e, logic dropped);
        exp_cnt++;
        if (!dropped) mbank[e.addr] = e.data;
        rd_addr = e.addr;
        #1;
        chk({nm, "_rd_new"}, 32'(rd_data), 32'(mbank[e.addr]));
        chk({nm, "_last_id"}, 32'(last_id), 32'(e.id));
        chk({nm, "_wr_cnt"}, 32'(wr_cnt), 32'(exp_cnt));
        chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset(string nm);
        req = '0; clr = 1'b0;
        resetn = 1'b0;
        #3;
        chk({nm, "_gnt"}, 32'(gnt), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_wr_cnt"}, 32'(wr_cnt), 32'd0);
        chk({nm, "_last_id"}, 32'(last_id), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            mbank[a] = 8'h00;
            rd_addr = 2'(a);
            #1;
            chk({nm, "_rd"}, 32'(rd_data), 32'd0);
        end
        exp_cnt = 0;
        sbq.delete();
        @(negedge clk);
        resetn = 1'b1;
        tick;
    endtask

    initial begin
        vec_t vecs[8];
        exp_t e;
        int   gseen;

        // rr_ptr evolution from reset: 0->3->0->1->2->1->0->2->2
        vecs[0] = '{4'b0100, 2'd3, 8'hA3, 2};
        vecs[1] = '{4'b1111, 2'd0, 8'h10, 3};
        vecs[2] = '{4'b1111, 2'd1, 8'h20, 0};
        vecs[3] = '{4'b1111, 2'd2, 8'h30, 1};
        vecs[4] = '{4'b0011, 2'd3, 8'h40, 0};
        vecs[5] = '{4'b1001, 2'd0, 8'h50, 3};
        vecs[6] = '{4'b0110, 2'd1, 8'h60, 1};
        vecs[7] = '{4'b0010, 2'd2, 8'h70, 1};

        req = '0; wr_addr = '0; wr_data = '0; clr = 1'b0; rd_addr = '0;
        do_reset("reset0");

        // Idle with no requests: no grant, pointer untouched.
        tick;
        chk("idle_gnt", 32'(gnt), 32'd0);

        foreach (vecs[v]) begin
            drive(vecs[v].req, vecs[v].addr, vecs[v].base);
            sbq.push_back('{id: vecs[v].win, addr: vecs[v].addr,
                            data: vecs[v].base + 8'(vecs[v].win)});
            tick;
            check_gnt($sformatf("vec%0d", v), e);
            drive(4'b0000, 2'd0, 8'hFF);
            tick;
            check_commit($sformatf("vec%0d", v), e, 1'b0);
        end

        // Bank is now preloaded; reset must clear it.
        do_reset("reset1");

        // Round-robin: all four requesters held, each drops after its grant.
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            wr_addr[i*AW +: AW] = 2'(i);
            wr_data[i*W +: W]   = 8'h10 + 8'(i);
            sbq.push_back('{id: i, addr: 2'(i), data: 8'h10 + 8'(i)});
        end
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (c % 2 == 1) begin
                check_gnt($sformatf("rr_c%0d", c), e);
                req[e.id] = 1'b0;
            end else begin
                check_commit($sformatf("rr_c%0d", c), e, 1'b0);
            end
        end

        // Starvation: 0 and 3 held continuously must alternate.
        drive(4'b1001, 2'd2, 8'hC0);
        for (int g = 0; g < 6; g++)
            sbq.push_back('{id: (g % 2 == 0) ? 0 : 3, addr: 2'd2,
                            data: (g % 2 == 0) ? 8'hC0 : 8'hC3});
        gseen = 0;
        for (int c = 0; c < 20 && gseen < 6; c++) begin
            tick;
            if (gnt != '0) begin
                check_gnt($sformatf("starve_g%0d", gseen), e);
                gseen++;
                if (gseen == 6) req = '0;
                tick;
                check_commit($sformatf("starve_g%0d", gseen), e, 1'b0);
            end
        end
        if (gseen != 6) begin
            n_tests++; n_fail++;
            $display("FAIL starve_timeout: got %0d grants expected 6", gseen);
        end

        // clr in the GNT cycle wins over the write; grant still consumed.
        drive(4'b0010, 2'd1, 8'h54);
        sbq.push_back('{id: 1, addr: 2'd1, data: 8'h55});
        tick;
        check_gnt("clr", e);
        req = '0;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        for (int a = 0; a < DEPTH; a++) mbank[a] = 8'h00;
        check_commit("clr", e, 1'b1);
        rd_addr = 2'd2;
        #1;
        chk("clr_rd2", 32'(rd_data), 32'd0);

        // Async reset during GNT discards the pending write and grant.
        drive(4'b0100, 2'd0, 8'hE0);
        tick;
        chk("rstgnt_gnt_pre", 32'(gnt), 32'b0100);
        req = '0;
        resetn = 1'b0;
        #1;
        chk("rstgnt_gnt", 32'(gnt), 32'd0);
        chk("rstgnt_busy", 32'(busy), 32'd0);
        chk("rstgnt_cnt", 32'(wr_cnt), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        exp_cnt = 0;
        sbq.delete();
        for (int a = 0; a < DEPTH; a++) mbank[a] = 8'h00;
        tick;
        rd_addr = 2'd0;
        #1;
        chk("rstgnt_rd0", 32'(rd_data), 32'd0);
        // Pointer back at 0: requester 1 beats requester 2.
        drive(4'b0110, 2'd3, 8'h80);
        sbq.push_back('{id: 1, addr: 2'd3, data: 8'h81});
        tick;
        check_gnt("rstgnt_after", e);
        req = '0;
        tick;
        check_commit("rstgnt_after", e, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
